// File: rtl/apb3_tim_dtg.sv
// Dead-time generator: turns each timer PWM reference into a complementary CH/CHN pair with break protection.
// Outputs follow TIM_CH after 2 cycles plus DTG dead time; the APB side is zero-wait (PREADY tied high).
module apb3_tim_dtg #(
   parameter int CHANNELS = 4,
   parameter int DT_WIDTH = 8
) (
   input  logic                io_apb_PCLK,
   input  logic                io_apb_PRESET,
   input  logic [4:0]          io_apb_PADDR,
   input  logic                io_apb_PSEL,
   input  logic                io_apb_PENABLE,
   input  logic                io_apb_PWRITE,
   input  logic [31:0]         io_apb_PWDATA,
   output logic                io_apb_PREADY,
   output logic [31:0]         io_apb_PRDATA,
   input  logic [CHANNELS-1:0] TIM_CH,
   input  logic                BRK,
   output logic [CHANNELS-1:0] CH,
   output logic [CHANNELS-1:0] CHN,
   output logic                interrupt
);

   typedef struct packed {
      logic bke;
      logic bkp;
      logic aoe;
      logic moe;
   } cr_t;

   typedef enum logic [3:0] {
      S_N    = 4'b0001,
      S_DT_P = 4'b0010,
      S_P    = 4'b0100,
      S_DT_N = 4'b1000
   } dtg_state_t;

   cr_t                  cr;
   logic [DT_WIDTH-1:0]  dtg;
   logic                 bif;
   logic                 bie;
   logic [CHANNELS-1:0]  ref_q;
   logic                 brk_m;
   logic                 brk_s;
   logic                 brk_q;
   logic                 brk_act;
   logic                 wr_en;
   logic                 dtg_zero;
   logic [DT_WIDTH-1:0]  dtg_m1;
   logic [31:0]          prdata;
   logic                 unused_wdata;

   assign wr_en         = io_apb_PSEL & io_apb_PENABLE & io_apb_PWRITE;
   assign brk_act       = cr.bke & (brk_s == cr.bkp);
   assign dtg_zero      = (dtg == '0);
   assign dtg_m1        = dtg - DT_WIDTH'(1);
   assign io_apb_PREADY = 1'b1;
   assign interrupt     = bie & bif;
   assign unused_wdata  = ^io_apb_PWDATA[31:DT_WIDTH];

   always_ff @(posedge io_apb_PCLK or posedge io_apb_PRESET) begin
      if (io_apb_PRESET) begin
         cr    <= '0;
         dtg   <= '0;
         bif   <= 1'b0;
         bie   <= 1'b0;
         ref_q <= '0;
         brk_m <= 1'b0;
         brk_s <= 1'b0;
         brk_q <= 1'b0;
      end else begin
         ref_q <= TIM_CH;
         brk_m <= BRK;
         brk_s <= brk_m;
         brk_q <= brk_act;
         if (wr_en && io_apb_PADDR == 5'd0) begin
            cr.bke <= io_apb_PWDATA[3];
            cr.bkp <= io_apb_PWDATA[2];
            cr.aoe <= io_apb_PWDATA[1];
         end
         // Break beats software; auto-restart fires on the first quiet edge after a break.
         if (brk_act)
            cr.moe <= 1'b0;
         else if (wr_en && io_apb_PADDR == 5'd0)
            cr.moe <= io_apb_PWDATA[0];
         else if (cr.aoe && brk_q)
            cr.moe <= 1'b1;
         if (wr_en && io_apb_PADDR == 5'd1)
            dtg <= io_apb_PWDATA[DT_WIDTH-1:0];
         if (brk_act)
            bif <= 1'b1;
         else if (wr_en && io_apb_PADDR == 5'd2 && io_apb_PWDATA[0])
            bif <= 1'b0;
         if (wr_en && io_apb_PADDR == 5'd3)
            bie <= io_apb_PWDATA[0];
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      dtg_state_t          state;
      logic [DT_WIDTH-1:0] cnt;

      // DTG is only sampled on dead-time entry, so a running count keeps its length.
      always_ff @(posedge io_apb_PCLK or posedge io_apb_PRESET) begin
         if (io_apb_PRESET) begin
            state <= S_N;
            cnt   <= '0;
         end else begin
            unique case (state)
               S_N: begin
                  if (ref_q[i]) begin
                     if (dtg_zero) state <= S_P;
                     else begin
                        state <= S_DT_P;
                        cnt   <= dtg_m1;
                     end
                  end
               end
               S_DT_P: begin
                  if (!ref_q[i]) begin
                     if (dtg_zero) state <= S_N;
                     else begin
                        state <= S_DT_N;
                        cnt   <= dtg_m1;
                     end
                  end else if (cnt == '0)
                     state <= S_P;
                  else
                     cnt <= cnt - DT_WIDTH'(1);
               end
               S_P: begin
                  if (!ref_q[i]) begin
                     if (dtg_zero) state <= S_N;
                     else begin
                        state <= S_DT_N;
                        cnt   <= dtg_m1;
                     end
                  end
               end
               S_DT_N: begin
                  if (ref_q[i]) begin
                     if (dtg_zero) state <= S_P;
                     else begin
                        state <= S_DT_P;
                        cnt   <= dtg_m1;
                     end
                  end else if (cnt == '0)
                     state <= S_N;
                  else
                     cnt <= cnt - DT_WIDTH'(1);
               end
               default: state <= S_N;
            endcase
         end
      end

      assign CH[i]  = (state == S_P) & cr.moe;
      assign CHN[i] = (state == S_N) & cr.moe;
   end

   always_comb begin
      prdata = '0;
      if (io_apb_PSEL && !io_apb_PWRITE) begin
         case (io_apb_PADDR)
            5'd0: prdata[3:0] = cr;
            5'd1: prdata[DT_WIDTH-1:0] = dtg;
            5'd2: prdata[0] = bif;
            5'd3: prdata[0] = bie;
            5'd4: prdata[2*CHANNELS-1:0] = {CHN, CH};
            default: prdata = '0;
         endcase
      end
   end

   assign io_apb_PRDATA = prdata;

endmodule
